// File: rtl/macro_frame_packer.sv
// Captures one armed frame of LBM macroscopic cells, buffers them and streams them out as 64-bit AXI4-Stream words.
// Optional FRAME_HEADER_EN prepends a {16'hCFD0, frame_seq, DEPTH} header word to every frame.
module macro_frame_packer #(
  parameter int DATA_WIDTH             = 16,
  parameter int DEPTH                  = 2500,
  parameter int FIFO_DEPTH             = 16,
  parameter int C_M00_AXIS_TDATA_WIDTH = 64
) (
  input  logic                                  m00_axis_aclk,
  input  logic                                  m00_axis_aresetn,
  input  logic                                  arm,
  input  logic                                  cell_valid,
  input  logic                                  cell_sof,
  input  logic [DATA_WIDTH-1:0]                 u_x,
  input  logic [DATA_WIDTH-1:0]                 u_y,
  input  logic [DATA_WIDTH-1:0]                 u_squared,
  input  logic [DATA_WIDTH-1:0]                 rho,
  output logic                                  m00_axis_tvalid,
  output logic [C_M00_AXIS_TDATA_WIDTH-1:0]     m00_axis_tdata,
  output logic [C_M00_AXIS_TDATA_WIDTH/8-1:0]   m00_axis_tstrb,
  output logic                                  m00_axis_tlast,
  input  logic                                  m00_axis_tready,
  output logic                                  busy,
  output logic                                  frame_done,
  output logic                                  overflow,
  output logic [15:0]                           frame_seq
);

  localparam int TW = C_M00_AXIS_TDATA_WIDTH;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] LAST_IDX    = CW'(DEPTH - 1);
  localparam logic [AW+1:0] DROP_LEVEL  = (AW + 2)'(FIFO_DEPTH - 1);
  localparam bit            SINGLE_CELL = (DEPTH == 1);

  typedef enum logic [1:0] {IDLE, ARMED, CAPTURE, DRAIN} state_t;

  state_t          state, state_nxt;
  logic            wr_en, drop, rd_en, handshake, frame_end;
  logic [TW:0]     wr_entry;
  logic [TW:0]     mem [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [AW:0]     count;
  logic [AW+1:0]   occupancy;
  logic [CW-1:0]   cell_cnt;
  logic [TW-1:0]   cell_word;

  assign cell_word      = {rho, u_squared, u_y, u_x};
  assign handshake      = m00_axis_tvalid && m00_axis_tready;
  assign rd_en          = (count != '0) && (!m00_axis_tvalid || m00_axis_tready);
  // Occupancy counts the word parked in the output register as well as the FIFO body.
  assign occupancy      = {1'b0, count} + {{(AW + 1){1'b0}}, m00_axis_tvalid};
  assign frame_end      = (state == DRAIN) && handshake && m00_axis_tlast;
  assign busy           = (state != IDLE);
  assign m00_axis_tstrb = '1;

  always_ff @(posedge m00_axis_aclk or negedge m00_axis_aresetn) begin
    if (!m00_axis_aresetn) state <= IDLE;
    else                   state <= state_nxt;
  end

  // NOTE: every signal driven here gets a default first, so no path can infer a latch.
  always_comb begin
    state_nxt = state;
    wr_en     = 1'b0;
    drop      = 1'b0;
    wr_entry  = {1'b0, cell_word};
    unique case (state)
      IDLE: if (arm) begin
        state_nxt = ARMED;
`ifdef FRAME_HEADER_EN
        wr_en    = 1'b1;
        wr_entry = {1'b0, TW'({16'hCFD0, frame_seq, 32'(DEPTH)})};
`endif
      end
      ARMED: if (cell_valid && cell_sof) begin
        wr_en     = 1'b1;
        wr_entry  = {SINGLE_CELL, cell_word};
        state_nxt = SINGLE_CELL ? DRAIN : CAPTURE;
      end
      CAPTURE: if (cell_valid) begin
        // The last cell bypasses the drop rule; earlier writes always leave it one slot.
        if (cell_cnt == LAST_IDX) begin
          wr_en     = 1'b1;
          wr_entry  = {1'b1, cell_word};
          state_nxt = DRAIN;
        end else if (occupancy < DROP_LEVEL) begin
          wr_en = 1'b1;
        end else begin
          drop = 1'b1;
        end
      end
      DRAIN: if (frame_end) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge m00_axis_aclk or negedge m00_axis_aresetn) begin
    if (!m00_axis_aresetn) begin
      cell_cnt <= '0;
    end else if (state == ARMED && cell_valid && cell_sof) begin
      cell_cnt <= SINGLE_CELL ? '0 : CW'(1);
    end else if (state == CAPTURE && cell_valid) begin
      cell_cnt <= (cell_cnt == LAST_IDX) ? '0 : cell_cnt + CW'(1);
    end
  end

  // NOTE: the FIFO storage has no reset; only pointers and count define its contents.
  always_ff @(posedge m00_axis_aclk) begin
    if (wr_en) mem[wr_ptr] <= wr_entry;
  end

  always_ff @(posedge m00_axis_aclk or negedge m00_axis_aresetn) begin
    if (!m00_axis_aresetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
      if (wr_en) wr_ptr <= wr_ptr + AW'(1);
      if (rd_en) rd_ptr <= rd_ptr + AW'(1);
      if (wr_en && !rd_en)      count <= count + (AW + 1)'(1);
      else if (!wr_en && rd_en) count <= count - (AW + 1)'(1);
    end
  end

  // Output register: reloads whenever it is empty or its word is being accepted.
  always_ff @(posedge m00_axis_aclk or negedge m00_axis_aresetn) begin
    if (!m00_axis_aresetn) begin
      m00_axis_tvalid <= 1'b0;
      m00_axis_tlast  <= 1'b0;
      m00_axis_tdata  <= '0;
    end else if (rd_en) begin
      m00_axis_tvalid <= 1'b1;
      {m00_axis_tlast, m00_axis_tdata} <= mem[rd_ptr];
    end else if (handshake) begin
      m00_axis_tvalid <= 1'b0;
      m00_axis_tlast  <= 1'b0;
    end
  end

  always_ff @(posedge m00_axis_aclk or negedge m00_axis_aresetn) begin
    if (!m00_axis_aresetn) begin
      overflow   <= 1'b0;
      frame_done <= 1'b0;
      frame_seq  <= '0;
    end else begin
      frame_done <= frame_end;
      if (frame_end) frame_seq <= frame_seq + 16'd1;
      if (state == IDLE && arm) overflow <= 1'b0;
      else if (drop)            overflow <= 1'b1;
    end
  end

endmodule
